// File: rtl/vec_dot_seq.sv
// Dot-product sequencer/accumulator in front of a C-lane vec_mul: issues one multiply per chunk,
// accumulates the pipelined partial sums, returns one signed result per job. Option: VEC_DOT_SAT_EN.
module vec_dot_seq #(
  parameter int C       = 4,
  parameter int W_X     = 8,
  parameter int W_K     = 8,
  parameter int LATENCY = $clog2(C) + 1,
  parameter int W_LEN   = 16,
  parameter int W_Y     = W_X + W_K + $clog2(C),
  parameter int W_ACC   = W_Y + W_LEN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [W_LEN-1:0]   cfg_len,
  output logic               busy,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [C*W_X-1:0]   in_x,
  input  logic [C*W_K-1:0]   in_k,
  output logic               mul_en,
  output logic [C*W_X-1:0]   mul_x,
  output logic [C*W_K-1:0]   mul_k,
  input  logic [W_Y-1:0]     mul_y,
  input  logic               mul_valid,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W_ACC-1:0]   out_data,
  output logic [2:0]         dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid never waits on
  // ready, and a producer holds its payload stable while valid is high and ready is low.

  typedef enum logic [2:0] {
    S_FLUSH = 3'd0,
    S_IDLE  = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int W_FC = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;
  localparam logic [W_FC-1:0] FLUSH_LAST = W_FC'(LATENCY - 1);

  state_t             state, state_d;
  logic [W_FC-1:0]    flush_cnt;
  logic [W_LEN-1:0]   len_q;
  logic [W_LEN-1:0]   issued_cnt;
  logic [W_LEN-1:0]   returned_cnt;
  logic [W_ACC-1:0]   acc;
  logic [W_ACC-1:0]   y_ext;
  logic [W_ACC-1:0]   acc_add;
  logic [W_ACC-1:0]   acc_upd;
  logic               accumulating;
  logic               final_return;

  assign dbg_state = state;
  assign busy      = (state != S_IDLE);
  assign in_ready  = (state == S_FEED) && (issued_cnt < len_q);
  assign mul_en    = in_valid && in_ready;
  assign mul_x     = in_x;
  assign mul_k     = in_k;

  assign y_ext        = W_ACC'($signed(mul_y));
  assign accumulating = mul_valid && ((state == S_FEED) || (state == S_DRAIN));
  assign acc_upd      = accumulating ? acc_add : acc;

  // The last partial sum may land in the same cycle the result is registered.
  assign final_return = (state == S_DRAIN) &&
                        ((returned_cnt == len_q) ||
                         (mul_valid && (returned_cnt == len_q - W_LEN'(1))));

`ifdef VEC_DOT_SAT_EN
  logic [W_ACC:0] sum_wide;
  always_comb begin
    sum_wide = {acc[W_ACC-1], acc} + {y_ext[W_ACC-1], y_ext};
    acc_add  = sum_wide[W_ACC-1:0];
    // Top two bits disagree only on overflow; clamp toward the sign of the true sum.
    if (sum_wide[W_ACC] != sum_wide[W_ACC-1]) begin
      acc_add = sum_wide[W_ACC] ? {1'b1, {(W_ACC-1){1'b0}}} : {1'b0, {(W_ACC-1){1'b1}}};
    end
  end
`else
  assign acc_add = acc + y_ext;
`endif

  always_comb begin
    state_d = state;
    case (state)
      S_FLUSH: if (flush_cnt == FLUSH_LAST) state_d = S_IDLE;
      S_IDLE:  if (start) state_d = (cfg_len == '0) ? S_DONE : S_FEED;
      S_FEED:  if (mul_en && (issued_cnt == len_q - W_LEN'(1))) state_d = S_DRAIN;
      S_DRAIN: if (final_return) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_FLUSH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_FLUSH;
      flush_cnt    <= '0;
      len_q        <= '0;
      issued_cnt   <= '0;
      returned_cnt <= '0;
      acc          <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
    end else begin
      state <= state_d;
      case (state)
        S_FLUSH: flush_cnt <= flush_cnt + W_FC'(1);
        S_IDLE: begin
          if (start) begin
            len_q        <= cfg_len;
            acc          <= '0;
            issued_cnt   <= '0;
            returned_cnt <= '0;
            if (cfg_len == '0) begin
              out_data  <= '0;
              out_valid <= 1'b1;
            end
          end
        end
        S_FEED, S_DRAIN: begin
          if (mul_en) issued_cnt <= issued_cnt + W_LEN'(1);
          if (accumulating) begin
            acc          <= acc_add;
            returned_cnt <= returned_cnt + W_LEN'(1);
          end
          if (final_return) begin
            out_data  <= acc_upd;
            out_valid <= 1'b1;
          end
        end
        S_DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_dot_seq.sv
// Directed bench for vec_dot_seq with a behavioural 4-lane vec_mul (3-stage pipeline) behind it.
module tb_vec_dot_seq;

  localparam int C = 4;
  localparam int W_X = 8;
  localparam int W_K = 8;
  localparam int W_LEN = 16;
  localparam int W_Y = 18;
  localparam int W_ACC = 18;

  localparam logic [2:0] ST_FLUSH = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_FEED  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [31:0] X_A = 32'h03020108;
  localparam logic [31:0] K_A = 32'h01030309;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [W_LEN-1:0]   cfg_len;
  logic               busy;
  logic               in_valid;
  logic               in_ready;
  logic [C*W_X-1:0]   in_x;
  logic [C*W_K-1:0]   in_k;
  logic               mul_en;
  logic [C*W_X-1:0]   mul_x;
  logic [C*W_K-1:0]   mul_k;
  logic [W_Y-1:0]     mul_y;
  logic               mul_valid;
  logic               out_valid;
  logic               out_ready;
  logic [W_ACC-1:0]   out_data;
  logic [2:0]         dbg_state;

  int errors = 0;
  int checks = 0;
  int mul_en_cnt = 0;

  always #5 clk = ~clk;

  vec_dot_seq #(.C(C), .W_X(W_X), .W_K(W_K), .W_LEN(W_LEN), .W_ACC(W_ACC)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_k(in_k),
    .mul_en(mul_en), .mul_x(mul_x), .mul_k(mul_k), .mul_y(mul_y), .mul_valid(mul_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .dbg_state(dbg_state)
  );

  // Behavioural vec_mul: not reset, so operations in flight survive a sequencer reset.
  logic [W_Y-1:0] model_y;
  logic [W_Y-1:0] y_pipe [3];
  logic [2:0]     v_pipe = '0;

  always_comb begin
    model_y = '0;
    for (int c = 0; c < C; c++) begin
      model_y = model_y + W_Y'($signed(mul_x[c*W_X +: W_X]) * $signed(mul_k[c*W_K +: W_K]));
    end
  end

  always @(posedge clk) begin
    v_pipe    <= {v_pipe[1:0], mul_en};
    y_pipe[0] <= model_y;
    y_pipe[1] <= y_pipe[0];
    y_pipe[2] <= y_pipe[1];
    if (mul_en) mul_en_cnt <= mul_en_cnt + 1;
  end

  assign mul_y     = y_pipe[2];
  assign mul_valid = v_pipe[2];

  task automatic do_start(input logic [W_LEN-1:0] len);
    start   = 1'b1;
    cfg_len = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_chunk(input logic [31:0] x, input logic [31:0] k);
    in_valid = 1'b1;
    in_x = x;
    in_k = k;
    for (int i = 0; i < 40 && !in_ready; i++) @(negedge clk);
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_chunk: in_ready=%0b required 1 within 40 cycles", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out_valid(input string name);
    for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: out_valid=%0b required 1 within 40 cycles", name, out_valid);
    end
  endtask

  task automatic finish_job(input string name);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_release: out_valid=%0b busy=%0b required 0 0", name, out_valid, busy);
    end
  endtask

  task automatic check_flush(input string name);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (busy !== 1'b1 || dbg_state !== ST_FLUSH || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s_flush%0d: busy=%0b state=%0d out_valid=%0b required 1 %0d 0",
                 name, i, busy, dbg_state, out_valid, ST_FLUSH);
      end
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL %s_idle: busy=%0b state=%0d required 0 %0d", name, busy, dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 ||
        dbg_state !== ST_FLUSH) begin
      errors++;
      $display("FAIL reset_values: busy=%0b in_ready=%0b out_valid=%0b out_data=%0d state=%0d required 1 0 0 0 0",
               busy, in_ready, out_valid, out_data, dbg_state);
    end
    rst = 1'b0;
    check_flush("reset");
  endtask

  task automatic test_single();
    int base;
    base = mul_en_cnt;
    do_start(16'd1);
    checks++;
    if (dbg_state !== ST_FEED || in_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_feed: state=%0d in_ready=%0b busy=%0b required %0d 1 1",
               dbg_state, in_ready, busy, ST_FEED);
    end
    in_x = X_A;
    in_k = K_A;
    #1;
    checks++;
    if (mul_x !== X_A || mul_k !== K_A) begin
      errors++;
      $display("FAIL passthrough: mul_x=%h mul_k=%h required %h %h", mul_x, mul_k, X_A, K_A);
    end
    send_chunk(X_A, K_A);
    wait_out_valid("single");
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 18'd84 || dbg_state !== ST_DONE) begin
        errors++;
        $display("FAIL single_hold%0d: out_valid=%0b out_data=%0d state=%0d required 1 84 %0d",
                 i, out_valid, out_data, dbg_state, ST_DONE);
      end
      @(negedge clk);
    end
    checks++;
    if (mul_en_cnt - base !== 1) begin
      errors++;
      $display("FAIL single_mul_en: pulses=%0d required 1", mul_en_cnt - base);
    end
    finish_job("single");
  endtask

  task automatic test_gaps();
    int base;
    base = mul_en_cnt;
    do_start(16'd3);
    for (int n = 0; n < 3; n++) begin
      send_chunk(X_A, K_A);
      if (n < 2) repeat (2) @(negedge clk);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL gaps_in_ready: in_ready=%0b required 0 after last chunk", in_ready);
    end
    wait_out_valid("gaps");
    checks++;
    if (out_data !== 18'd252) begin
      errors++;
      $display("FAIL gaps_data: out_data=%0d required 252", out_data);
    end
    checks++;
    if (mul_en_cnt - base !== 3) begin
      errors++;
      $display("FAIL gaps_mul_en: pulses=%0d required 3", mul_en_cnt - base);
    end
    finish_job("gaps");
  endtask

  task automatic test_zero_len();
    int base;
    base = mul_en_cnt;
    do_start(16'd0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== '0 || dbg_state !== ST_DONE || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL zero_len: out_valid=%0b out_data=%0d state=%0d in_ready=%0b required 1 0 %0d 0",
               out_valid, out_data, dbg_state, in_ready, ST_DONE);
    end
    finish_job("zero_len");
    checks++;
    if (mul_en_cnt - base !== 0) begin
      errors++;
      $display("FAIL zero_len_mul_en: pulses=%0d required 0", mul_en_cnt - base);
    end
  endtask

  task automatic test_done_hold();
    do_start(16'd1);
    send_chunk(X_A, K_A);
    wait_out_valid("hold");
    for (int i = 0; i < 5; i++) begin
      start   = (i == 2);
      cfg_len = 16'd2;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 18'd84 || in_ready !== 1'b0 || dbg_state !== ST_DONE) begin
        errors++;
        $display("FAIL hold%0d: out_valid=%0b out_data=%0d in_ready=%0b state=%0d required 1 84 0 %0d",
                 i, out_valid, out_data, in_ready, dbg_state, ST_DONE);
      end
      @(negedge clk);
    end
    // Start coincident with the result handshake must be dropped.
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (dbg_state !== ST_IDLE || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_start_ignored: state=%0d busy=%0b out_valid=%0b required %0d 0 0",
               dbg_state, busy, out_valid, ST_IDLE);
    end
    @(negedge clk);
    checks++;
    if (dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL hold_still_idle: state=%0d required %0d", dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_reset_mid_feed();
    do_start(16'd4);
    send_chunk(X_A, K_A);
    send_chunk(X_A, K_A);
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 ||
        dbg_state !== ST_FLUSH) begin
      errors++;
      $display("FAIL midfeed_reset: busy=%0b in_ready=%0b out_valid=%0b out_data=%0d state=%0d required 1 0 0 0 0",
               busy, in_ready, out_valid, out_data, dbg_state);
    end
    @(negedge clk);
    rst = 1'b0;
    check_flush("midfeed");
    do_start(16'd1);
    send_chunk(X_A, K_A);
    wait_out_valid("midfeed_job");
    checks++;
    if (out_data !== 18'd84) begin
      errors++;
      $display("FAIL midfeed_data: out_data=%0d required 84", out_data);
    end
    finish_job("midfeed");
  endtask

  task automatic test_wrap();
    logic [W_ACC-1:0] exp;
`ifdef VEC_DOT_SAT_EN
    exp = 18'h1FFFF;
`else
    exp = 18'h20000;
`endif
    do_start(16'd2);
    send_chunk(32'h80808080, 32'h80808080);
    send_chunk(32'h80808080, 32'h80808080);
    wait_out_valid("wrap");
    checks++;
    if (out_data !== exp) begin
      errors++;
      $display("FAIL wrap_data: out_data=%0d required %0d", $signed(out_data), $signed(exp));
    end
    finish_job("wrap");
  endtask

  task automatic test_sat_recover();
    logic [W_ACC-1:0] exp;
`ifdef VEC_DOT_SAT_EN
    exp = 18'd66047;
`else
    exp = 18'd66048;
`endif
    do_start(16'd3);
    send_chunk(32'h80808080, 32'h80808080);
    send_chunk(32'h80808080, 32'h80808080);
    send_chunk(32'h80808080, 32'h7F7F7F7F);
    wait_out_valid("recover");
    checks++;
    if (out_data !== exp) begin
      errors++;
      $display("FAIL recover_data: out_data=%0d required %0d", $signed(out_data), $signed(exp));
    end
    finish_job("recover");
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    cfg_len = '0;
    in_valid = 1'b0;
    in_x = '0;
    in_k = '0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_gaps();
    test_zero_len();
    test_done_hold();
    test_reset_mid_feed();
    test_wrap();
    test_sat_recover();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
